// File: rtl/imem_responder_if.sv
// Fetch-port bundle between a core (master) and its instruction memory (slave).
interface imem_responder_if;
    logic [31:0] io_imem_addr;
    logic        io_imem_ready;
    logic [31:0] io_imem_rdata;
    logic        io_imem_fault;

    modport master (
        output io_imem_addr,
        input  io_imem_ready,
        input  io_imem_rdata,
        input  io_imem_fault
    );

    modport slave (
        input  io_imem_addr,
        output io_imem_ready,
        output io_imem_rdata,
        output io_imem_fault
    );
endinterface

// File: rtl/imem_responder.sv
// Instruction-memory model: word-addressed program store, fixed fetch latency and
// bounded stall injection. Define IMEM_FAULT_EN to flag misaligned/out-of-range fetches.
module imem_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2,
    parameter int MAX_STALL  = 4
) (
    input  logic              clock,
    input  logic              reset,
    imem_responder_if.slave   imem,
    input  logic              stall_req,
    input  logic              load_en,
    input  logic [31:0]       load_addr,
    input  logic [31:0]       load_data
);
    localparam int CW    = $clog2(LATENCY + 1);
    localparam int SW    = (MAX_STALL < 1) ? 1 : $clog2(MAX_STALL + 1);
    localparam int WORDS = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t                state, state_d;
    logic [CW-1:0]         cnt, cnt_d;
    logic [SW-1:0]         stall_run, stall_run_d;
    logic [31:0]           req_addr;
    logic                  latch_addr;
    logic                  resp_load;
    logic                  stall_eff;
    logic                  fetch_fault;
    logic                  ready_q;
    logic [31:0]           rdata_q;
    logic [31:0]           mem [0:WORDS-1];
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic [DEPTH_LOG2-1:0] wr_idx;

    assign rd_idx = req_addr[DEPTH_LOG2+1:2];
    assign wr_idx = load_addr[DEPTH_LOG2+1:2];

    // The stall budget is per fetch: stall_run only clears when WAIT is left,
    // so a fetch always finishes within LATENCY+MAX_STALL WAIT cycles.
    assign stall_eff = stall_req && (stall_run < SW'(MAX_STALL));

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        stall_run_d = stall_run;
        latch_addr  = 1'b0;
        resp_load   = 1'b0;
        case (state)
            IDLE: begin
                latch_addr = 1'b1;
                cnt_d      = CW'(LATENCY);
                state_d    = WAIT;
            end
            WAIT: begin
                if (stall_eff) begin
                    stall_run_d = stall_run + 1'b1;
                end else if (cnt == CW'(1)) begin
                    stall_run_d = '0;
                    resp_load   = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            stall_run <= '0;
            req_addr  <= '0;
            ready_q   <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            stall_run <= stall_run_d;
            ready_q   <= resp_load;
            if (latch_addr)
                req_addr <= imem.io_imem_addr;
            // Read happens before any same-edge load lands in mem.
            if (resp_load)
                rdata_q <= fetch_fault ? 32'h0000_0000 : mem[rd_idx];
        end
    end

    // Loads are independent of the FSM and of reset.
    always_ff @(posedge clock) begin
        if (load_en)
            mem[wr_idx] <= load_data;
    end

    assign imem.io_imem_ready = ready_q;
    assign imem.io_imem_rdata = rdata_q;

    logic unused_load_bits;
    assign unused_load_bits = ^{load_addr[31:DEPTH_LOG2+2], load_addr[1:0]};

`ifdef IMEM_FAULT_EN
    logic fault_q;

    assign fetch_fault = (req_addr[1:0] != 2'b00) || (req_addr[31:DEPTH_LOG2+2] != '0);

    always_ff @(posedge clock) begin
        if (reset)
            fault_q <= 1'b0;
        else
            fault_q <= resp_load && fetch_fault;
    end

    assign imem.io_imem_fault = fault_q;
`else
    logic unused_req_bits;

    assign fetch_fault        = 1'b0;
    assign imem.io_imem_fault = 1'b0;
    assign unused_req_bits    = ^{req_addr[31:DEPTH_LOG2+2], req_addr[1:0]};
`endif

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: directed fetch scenarios plus randomized
// traffic compared every cycle against a fetch-level behavioural model.
module tb_imem_responder;
  localparam int DL  = 10;
  localparam int LAT = 2;
  localparam int MS  = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall_req;
  logic        load_en;
  logic [31:0] load_addr;
  logic [31:0] load_data;

  imem_responder_if imem ();

  imem_responder #(.DEPTH_LOG2(DL), .LATENCY(LAT), .MAX_STALL(MS)) dut (
    .clock    (clock),
    .reset    (reset),
    .imem     (imem),
    .stall_req(stall_req),
    .load_en  (load_en),
    .load_addr(load_addr),
    .load_data(load_data)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_mem [0:(1<<DL)-1];
  bit          m_live     = 1'b0;
  bit          f_open     = 1'b0;  // a fetch has been sampled and is not yet answered
  bit          resp_cycle = 1'b0;  // the cycle now starting carries the answer
  int          f_good, f_stalls;
  logic [31:0] f_addr;
  bit          exp_ready, exp_fault, prev_ready;
  logic [31:0] exp_rdata = '0;
  int          edge_n = 0;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return m_mem[DL'(a >> 2)];
  endfunction

  function automatic bit faulty(input logic [31:0] a);
`ifdef IMEM_FAULT_EN
    return ((a % 4) != 0) || ((a >> (DL + 2)) != 0);
`else
    return (a == 32'hFFFF_FFFF) && (a != 32'hFFFF_FFFF);
`endif
  endfunction

  always @(posedge clock) begin
    edge_n++;
    exp_ready = 1'b0;
    exp_fault = 1'b0;
    if (reset) begin
      f_open     = 1'b0;
      resp_cycle = 1'b0;
      exp_rdata  = '0;
      m_live     = 1'b1;
    end else if (resp_cycle) begin
      resp_cycle = 1'b0;
    end else if (!f_open) begin
      f_open   = 1'b1;
      f_addr   = imem.io_imem_addr;
      f_good   = 0;
      f_stalls = 0;
    end else if (stall_req && f_stalls < MS) begin
      f_stalls++;
    end else begin
      f_good++;
      if (f_good == LAT) begin
        f_open     = 1'b0;
        resp_cycle = 1'b1;
        exp_ready  = 1'b1;
        exp_fault  = faulty(f_addr);
        exp_rdata  = exp_fault ? 32'h0 : word_of(f_addr);
      end
    end
    if (load_en) m_mem[DL'(load_addr >> 2)] = load_data;
    #1;
    if (m_live) begin
      chk("ready", 32'(imem.io_imem_ready), 32'(exp_ready));
      chk("rdata", imem.io_imem_rdata, exp_rdata);
      chk("fault", 32'(imem.io_imem_fault), 32'(exp_fault));
      chk("ready_adjacent", 32'(imem.io_imem_ready && prev_ready), 32'h0);
    end
    prev_ready = imem.io_imem_ready;
  end

  // ---------------- directed helpers ----------------
  // Precondition: the next rising edge is an IDLE sample. Returns after the RESP
  // cycle has ended, so the following edge is again an IDLE sample.
  task automatic fetch(input logic [31:0] a, input int stall_len, input int load_at,
                       input logic [31:0] la, input logic [31:0] ld,
                       output int lat, output logic [31:0] data, output logic flt,
                       output int redge);
    int k;
    k = 0;
    imem.io_imem_addr = a;
    stall_req = (stall_len > 0);
    load_addr = la;
    load_data = ld;
    load_en   = 1'b0;
    lat = -1; data = '0; flt = 1'b0; redge = -1;
    while (lat < 0 && k < 60) begin
      @(posedge clock); #1;
      k++;
      if (imem.io_imem_ready) begin
        lat   = k;
        data  = imem.io_imem_rdata;
        flt   = imem.io_imem_fault;
        redge = edge_n;
      end
      load_en = (lat < 0) && (k + 1 == load_at);
      if (k > stall_len) stall_req = 1'b0;
    end
    load_en   = 1'b0;
    stall_req = 1'b0;
    if (lat < 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL fetch_timeout: addr %h got no ready in 60 cycles, expected one", a);
    end
    @(posedge clock); #1;
  endtask

  int          lat, r1, r2, r3;
  logic [31:0] d;
  logic        f;

  initial begin
    reset = 1'b1; stall_req = 1'b0; load_en = 1'b0;
    load_addr = '0; load_data = '0; imem.io_imem_addr = '0;

    // Preload the whole store while reset is held.
    for (int i = 0; i < (1 << DL); i++) begin
      @(negedge clock);
      load_en   = 1'b1;
      load_addr = 32'(i * 4);
      load_data = (i == 0) ? 32'h0000_0013 : 32'h1000_0000 + 32'(i);
    end
    @(negedge clock);
    load_en = 1'b0;
    @(negedge clock);
    reset = 1'b0;

    // Basic fetch of word 0.
    fetch(32'h0, 0, 0, 0, 0, lat, d, f, r1);
    chk("basic_latency", 32'(lat), 32'd3);
    chk("basic_rdata", d, 32'h0000_0013);
    chk("basic_ready_drop", 32'(imem.io_imem_ready), 32'h0);

    // Stall held far longer than the budget: only MS cycles honoured.
    fetch(32'h0, 10, 0, 0, 0, lat, d, f, r1);
    chk("stall_latency", 32'(lat), 32'd7);
    chk("stall_rdata", d, 32'h0000_0013);

    // Back-to-back fetches.
    fetch(32'h0, 0, 0, 0, 0, lat, d, f, r1);
    chk("b2b_w0", d, 32'h0000_0013);
    fetch(32'h4, 0, 0, 0, 0, lat, d, f, r2);
    chk("b2b_w1", d, 32'h1000_0001);
    fetch(32'h8, 0, 0, 0, 0, lat, d, f, r3);
    chk("b2b_w2", d, 32'h1000_0002);
    chk("b2b_gap1", 32'(r2 - r1), 32'd4);
    chk("b2b_gap2", 32'(r3 - r2), 32'd4);

    // Load on the RESP-entry edge is not seen by that read.
    fetch(32'h4, 0, 3, 32'h4, 32'hDEAD_BEEF, lat, d, f, r1);
    chk("rbw_old", d, 32'h1000_0001);
    fetch(32'h4, 0, 0, 0, 0, lat, d, f, r1);
    chk("rbw_new", d, 32'hDEAD_BEEF);

    // Reset in the middle of WAIT drops the fetch.
    imem.io_imem_addr = 32'h8;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    chk("rst_ready", 32'(imem.io_imem_ready), 32'h0);
    chk("rst_rdata", imem.io_imem_rdata, 32'h0);
    chk("rst_fault", 32'(imem.io_imem_fault), 32'h0);
    reset = 1'b0;
    fetch(32'h8, 0, 0, 0, 0, lat, d, f, r1);
    chk("post_rst_latency", 32'(lat), 32'd3);
    chk("post_rst_rdata", d, 32'h1000_0002);

    // Misaligned fetch.
    fetch(32'h2, 0, 0, 0, 0, lat, d, f, r1);
`ifdef IMEM_FAULT_EN
    chk("mis_rdata", d, 32'h0);
    chk("mis_fault", 32'(f), 32'h1);
`else
    chk("mis_rdata", d, 32'h0000_0013);
    chk("mis_fault", 32'(f), 32'h0);
`endif
    chk("mis_latency", 32'(lat), 32'd3);

    // Randomized traffic, checked every cycle by the model.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      stall_req = ($urandom % 3) == 0;
      imem.io_imem_addr = (($urandom % 4) == 0) ? $urandom : 32'($urandom_range(0, 1023)) << 2;
      load_en   = ($urandom % 8) == 0;
      load_addr = (($urandom % 2) == 0) ? $urandom : 32'($urandom_range(0, 15)) << 2;
      load_data = $urandom;
      reset     = ($urandom % 200) == 0;
    end
    @(negedge clock);
    reset = 1'b0; load_en = 1'b0; stall_req = 1'b0;
    repeat (10) @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
